// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Parametrised pipeline-stage register with valid/ready
//               handshake, stall/flush controls and a 2-entry skid buffer
//               so that in_ready is a flop output. Exposes occupancy and a
//               saturating stall-cycle counter for performance debug.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,        // synchronous, active-low
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic [RD_W-1:0]   out_rd,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    // Main entry drives the outputs; skid entry catches one beat under backpressure
    logic              r_main_valid, r_skid_valid;
    logic [CTRL_W-1:0] r_main_ctrl,  r_skid_ctrl;
    logic [DATA_W-1:0] r_main_data,  r_skid_data;
    logic [ADDR_W-1:0] r_main_addr,  r_skid_addr;
    logic [RD_W-1:0]   r_main_rd,    r_skid_rd;
    logic              r_in_ready;
    logic [1:0]        r_occupancy;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_main_valid_nxt, w_skid_valid_nxt;
    logic [CTRL_W-1:0] w_main_ctrl_nxt,  w_skid_ctrl_nxt;
    logic [DATA_W-1:0] w_main_data_nxt,  w_skid_data_nxt;
    logic [ADDR_W-1:0] w_main_addr_nxt,  w_skid_addr_nxt;
    logic [RD_W-1:0]   w_main_rd_nxt,    w_skid_rd_nxt;

    logic w_in_fire, w_out_fire;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_main_valid & out_ready & ~stall;

    // Next-state of both entries; flush zeroes ctrl so stale fields read as bubbles
    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_ctrl_nxt  = r_main_ctrl;
        w_main_data_nxt  = r_main_data;
        w_main_addr_nxt  = r_main_addr;
        w_main_rd_nxt    = r_main_rd;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_ctrl_nxt  = r_skid_ctrl;
        w_skid_data_nxt  = r_skid_data;
        w_skid_addr_nxt  = r_skid_addr;
        w_skid_rd_nxt    = r_skid_rd;
        if (flush) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
            w_main_ctrl_nxt  = '0;
            w_skid_ctrl_nxt  = '0;
        end else if (!r_main_valid) begin
            if (w_in_fire) begin
                w_main_valid_nxt = 1'b1;
                w_main_ctrl_nxt  = in_ctrl;
                w_main_data_nxt  = in_data;
                w_main_addr_nxt  = in_addr;
                w_main_rd_nxt    = in_rd;
            end
        end else if (w_out_fire) begin
            if (r_skid_valid) begin
                // in_ready is low here, so no input can collide with the refill
                w_main_ctrl_nxt  = r_skid_ctrl;
                w_main_data_nxt  = r_skid_data;
                w_main_addr_nxt  = r_skid_addr;
                w_main_rd_nxt    = r_skid_rd;
                w_skid_valid_nxt = 1'b0;
            end else if (w_in_fire) begin
                w_main_ctrl_nxt  = in_ctrl;
                w_main_data_nxt  = in_data;
                w_main_addr_nxt  = in_addr;
                w_main_rd_nxt    = in_rd;
            end else begin
                w_main_valid_nxt = 1'b0;
            end
        end else if (w_in_fire) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_ctrl_nxt  = in_ctrl;
            w_skid_data_nxt  = in_data;
            w_skid_addr_nxt  = in_addr;
            w_skid_rd_nxt    = in_rd;
        end
    end

    // Entry registers plus registered in_ready/occupancy derived from next state
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_main_data  <= '0;
            r_main_addr  <= '0;
            r_main_rd    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
            r_skid_data  <= '0;
            r_skid_addr  <= '0;
            r_skid_rd    <= '0;
            r_in_ready   <= 1'b1;
            r_occupancy  <= 2'd0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_main_ctrl  <= w_main_ctrl_nxt;
            r_main_data  <= w_main_data_nxt;
            r_main_addr  <= w_main_addr_nxt;
            r_main_rd    <= w_main_rd_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_ctrl  <= w_skid_ctrl_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_skid_addr  <= w_skid_addr_nxt;
            r_skid_rd    <= w_skid_rd_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
            r_occupancy  <= {1'b0, w_main_valid_nxt} + {1'b0, w_skid_valid_nxt};
        end
    end

    // Saturating count of cycles where a beat is presented but not consumed
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (!flush && r_main_valid && !w_out_fire && r_stall_cnt != C_CNT_MAX) begin
            r_stall_cnt <= r_stall_cnt + C_CNT_ONE;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_main_valid;
    assign out_ctrl  = r_main_ctrl;
    assign out_data  = r_main_data;
    assign out_addr  = r_main_addr;
    assign out_rd    = r_main_rd;
    assign occupancy = r_occupancy;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg. A queue-based model
//               of the stage (FIFO of up to two beats) predicts every output.
//               A second instance with a 3-bit counter covers saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] data;
        logic [31:0] addr;
        logic [4:0]  rd;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        in_valid, out_ready, stall, flush;
    logic [3:0]  in_ctrl;
    logic [31:0] in_data, in_addr;
    logic [4:0]  in_rd;

    logic        in_ready, out_valid;
    logic [3:0]  out_ctrl;
    logic [31:0] out_data, out_addr;
    logic [4:0]  out_rd;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    logic        s_in_ready, s_out_valid;
    logic [3:0]  s_out_ctrl;
    logic [31:0] s_out_data, s_out_addr;
    logic [4:0]  s_out_rd;
    logic [1:0]  s_occupancy;
    logic [2:0]  s_stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: FIFO of held beats, last visible output, unbounded count
    beat_t           m_q[$];
    beat_t           m_out;
    longint unsigned m_cnt;

    pipe_stage_reg dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_addr(in_addr), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data), .out_addr(out_addr), .out_rd(out_rd),
        .stall(stall), .flush(flush),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_addr(in_addr), .in_rd(in_rd),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_ctrl(s_out_ctrl), .out_data(s_out_data), .out_addr(s_out_addr), .out_rd(s_out_rd),
        .stall(stall), .flush(flush),
        .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_edge();
        bit in_fire, out_fire;
        if (!rst) begin
            m_q.delete();
            m_out = '0;
            m_cnt = 0;
            return;
        end
        in_fire = in_valid && (m_q.size() < 2);
        if (flush) begin
            m_q.delete();
            m_out.ctrl = '0;
            return;
        end
        out_fire = (m_q.size() > 0) && out_ready && !stall;
        if (m_q.size() > 0 && !out_fire) m_cnt++;
        if (out_fire) void'(m_q.pop_front());
        if (in_fire) m_q.push_back(beat_t'{in_ctrl, in_data, in_addr, in_rd});
        if (m_q.size() > 0) m_out = m_q[0];
    endfunction

    function automatic logic [15:0] exp_cnt16();
        return (m_cnt > 64'd65535) ? 16'hFFFF : m_cnt[15:0];
    endfunction

    function automatic logic [2:0] exp_cnt3();
        return (m_cnt > 64'd7) ? 3'd7 : m_cnt[2:0];
    endfunction

    // Advance one clock: model sees the same inputs the DUT samples
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic v, input logic [3:0] c, input logic [31:0] d,
                              input logic [31:0] a, input logic [4:0] r);
        in_valid = v; in_ctrl = c; in_data = d; in_addr = a; in_rd = r;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; stall = 1'b0; out_ready = 1'b0;
        drive_beat(1'b1, 4'hF, 32'hDEAD_BEEF, 32'h1234_5678, 5'd3);
        step();
        step();
        n_checks++;
        if ({out_valid, in_ready, occupancy} !== {1'b0, 1'b1, 2'd0}) begin
            n_errors++;
            $display("FAIL reset_flags: valid/ready/occ got %b/%b/%0d want 0/1/0", out_valid, in_ready, occupancy);
        end
        n_checks++;
        if ({out_ctrl, out_data, out_addr, out_rd} !== '0) begin
            n_errors++;
            $display("FAIL reset_fields: ctrl=%h data=%h addr=%h rd=%h want all 0", out_ctrl, out_data, out_addr, out_rd);
        end
        n_checks++;
        if (stall_cnt !== 16'd0 || s_stall_cnt !== 3'd0) begin
            n_errors++;
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, s_stall_cnt);
        end
        rst = 1'b1;
        drive_beat(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic test_streaming();
        logic [31:0] vals [3] = '{32'h11, 32'h22, 32'h33};
        out_ready = 1'b1; stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_beat(1'b1, 4'h1, vals[i], 32'h100 + i, 5'(i + 1));
            step();
            n_checks++;
            if (!out_valid || out_data !== vals[i] || !in_ready || occupancy > 2'd1) begin
                n_errors++;
                $display("FAIL stream_%0d: valid=%b data=%h ready=%b occ=%0d want 1/%h/1/<=1",
                         i, out_valid, out_data, in_ready, occupancy, vals[i]);
            end
        end
        drive_beat(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        step();
        n_checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            n_errors++;
            $display("FAIL stream_drain: valid=%b occ=%0d want 0/0", out_valid, occupancy);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; stall = 1'b0;
        drive_beat(1'b1, 4'h2, 32'hAAAA_0000, 32'hA, 5'd10);
        step();
        drive_beat(1'b1, 4'h3, 32'hBBBB_0000, 32'hB, 5'd11);
        step();
        n_checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hAAAA_0000) begin
            n_errors++;
            $display("FAIL bp_full: occ=%0d ready=%b data=%h want 2/0/aaaa0000", occupancy, in_ready, out_data);
        end
        drive_beat(1'b1, 4'h4, 32'hCCCC_0000, 32'hC, 5'd12);
        step();
        n_checks++;
        if (occupancy !== 2'd2 || out_data !== 32'hAAAA_0000) begin
            n_errors++;
            $display("FAIL bp_hold: occ=%0d data=%h want 2/aaaa0000", occupancy, out_data);
        end
        out_ready = 1'b1;
        step();
        n_checks++;
        if (!out_valid || out_data !== 32'hBBBB_0000 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_b: valid=%b data=%h ready=%b want 1/bbbb0000/1", out_valid, out_data, in_ready);
        end
        step();
        drive_beat(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        n_checks++;
        if (!out_valid || out_data !== 32'hCCCC_0000 || occupancy !== 2'd1) begin
            n_errors++;
            $display("FAIL bp_c: valid=%b data=%h occ=%0d want 1/cccc0000/1", out_valid, out_data, occupancy);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_dup: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_stall();
        logic [15:0] base;
        out_ready = 1'b1; stall = 1'b1;
        drive_beat(1'b1, 4'h5, 32'h5555_1234, 32'h55, 5'd5);
        step();
        drive_beat(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        base = exp_cnt16();
        for (int i = 1; i <= 5; i++) begin
            step();
            n_checks++;
            if (!out_valid || out_data !== 32'h5555_1234 || stall_cnt !== base + 16'(i)) begin
                n_errors++;
                $display("FAIL stall_%0d: valid=%b data=%h cnt=%0d want 1/55551234/%0d",
                         i, out_valid, out_data, stall_cnt, base + 16'(i));
            end
        end
        stall = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || stall_cnt !== base + 16'd5) begin
            n_errors++;
            $display("FAIL stall_release: valid=%b cnt=%0d want 0/%0d", out_valid, stall_cnt, base + 16'd5);
        end
    endtask

    task automatic test_flush();
        logic [15:0] base;
        out_ready = 1'b0; stall = 1'b0;
        drive_beat(1'b1, 4'h6, 32'h6666_0001, 32'h61, 5'd1);
        step();
        drive_beat(1'b1, 4'h6, 32'h6666_0002, 32'h62, 5'd2);
        step();
        base = exp_cnt16();
        flush = 1'b1;
        drive_beat(1'b1, 4'h7, 32'h7777_0000, 32'h70, 5'd7);
        step();
        flush = 1'b0;
        drive_beat(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        n_checks++;
        if ({out_valid, out_ctrl, occupancy, in_ready} !== {1'b0, 4'h0, 2'd0, 1'b1}) begin
            n_errors++;
            $display("FAIL flush_state: valid=%b ctrl=%h occ=%0d ready=%b want 0/0/0/1",
                     out_valid, out_ctrl, occupancy, in_ready);
        end
        n_checks++;
        if (out_data !== 32'h6666_0001 || stall_cnt !== base) begin
            n_errors++;
            $display("FAIL flush_keep: data=%h cnt=%0d want 66660001/%0d", out_data, stall_cnt, base);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b0 || out_rd === 5'd7) begin
                n_errors++;
                $display("FAIL flush_leak_%0d: valid=%b rd=%0d want 0/not 7", i, out_valid, out_rd);
            end
        end
    endtask

    task automatic test_saturation();
        rst = 1'b0;
        step();
        rst = 1'b1; out_ready = 1'b0; stall = 1'b0;
        drive_beat(1'b1, 4'h8, 32'h8888_0000, 32'h80, 5'd8);
        step();
        drive_beat(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i >= 10) begin
                n_checks++;
                if (s_stall_cnt !== 3'd7 || stall_cnt !== 16'(i)) begin
                    n_errors++;
                    $display("FAIL sat_%0d: cnt3=%0d cnt16=%0d want 7/%0d", i, s_stall_cnt, stall_cnt, i);
                end
            end
        end
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_random();
        bit hold_beat;
        hold_beat = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!hold_beat)
                drive_beat($urandom_range(0, 99) < 60, 4'($urandom_range(1, 15)), $urandom,
                           $urandom, 5'($urandom));
            out_ready = $urandom_range(0, 99) < 55;
            stall     = $urandom_range(0, 99) < 20;
            flush     = $urandom_range(0, 99) < 4;
            rst       = !($urandom_range(0, 99) < 2);
            hold_beat = in_valid && (m_q.size() >= 2) && rst && !flush;
            step();
            n_checks++;
            if ({out_valid, in_ready, occupancy} !== {m_q.size() > 0, m_q.size() < 2, 2'(m_q.size())}) begin
                n_errors++;
                $display("FAIL rand_flags_%0d: valid/ready/occ got %b/%b/%0d want %b/%b/%0d", i,
                         out_valid, in_ready, occupancy, m_q.size() > 0, m_q.size() < 2, m_q.size());
            end
            n_checks++;
            if ({out_ctrl, out_data, out_addr, out_rd} !== m_out) begin
                n_errors++;
                $display("FAIL rand_fields_%0d: got %h/%h/%h/%h want %h/%h/%h/%h", i,
                         out_ctrl, out_data, out_addr, out_rd, m_out.ctrl, m_out.data, m_out.addr, m_out.rd);
            end
            n_checks++;
            if (stall_cnt !== exp_cnt16() || s_stall_cnt !== exp_cnt3()) begin
                n_errors++;
                $display("FAIL rand_cnt_%0d: got %0d/%0d want %0d/%0d", i,
                         stall_cnt, s_stall_cnt, exp_cnt16(), exp_cnt3());
            end
        end
        rst = 1'b1; flush = 1'b0; stall = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0; out_ready = 1'b0;
        drive_beat(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        m_out = '0; m_cnt = 0;
        #2;
        test_reset();
        test_streaming();
        test_backpressure();
        test_stall();
        test_flush();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register for the MIPS pipeline. It generalises the fixed MEM/WB register with configurable field widths, a valid/ready handshake, stall and flush controls, and a 2-entry skid buffer, so that `in_ready` is registered.
- One instance serves any inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- It also exposes occupancy and a saturating stall-cycle counter for performance debug.

Parameters:
- CTRL_W, 4, width of the control/writeback bundle (a value of 0 in this bundle is a bubble).
- DATA_W, 32, width of the data field (e.g. memory read data).
- ADDR_W, 32, width of the address/ALU-result field.
- RD_W, 5, width of the destination-register field.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-low; sampled on the rising edge of `clk`.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat; registered, equals NOT skid_valid.
- in_ctrl  in  CTRL_W  control bundle.
- in_data  in  DATA_W  data field.
- in_addr  in  ADDR_W  address field.
- in_rd  in  RD_W  destination register.
- out_valid  out  1  main entry holds a beat.
- out_ready  in  1  downstream accepts.
- out_ctrl/out_data/out_addr/out_rd  out  CTRL_W/DATA_W/ADDR_W/RD_W  main entry fields.
- stall  in  1  hazard hold; blocks consumption.
- flush  in  1  discard all held beats (branch/exception).
- occupancy  out  2  entries held, 0..2.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and no consumption.

Behaviour:
- Storage: main entry (drives the `out_*` ports) and skid entry. Each entry has a valid bit plus ctrl/data/addr/rd fields.
- Handshake signals:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready & ~stall.
  - Upstream must hold its fields stable while in_valid=1 and in_ready=0.
- Reset (rst=0 at a posedge):
  - main_valid=0, skid_valid=0, so out_valid=0 and in_ready=1.
  - All `out_*` fields = 0; the skid fields = 0.
  - occupancy=0, stall_cnt=0.
  - Reset overrides flush and all traffic, including a reset asserted mid-transfer.
- Flush (rst=1, flush=1):
  - Both valid bits are cleared. out_ctrl and the skid ctrl are zeroed, which makes them bubbles.
  - data/addr/rd keep their values.
  - A beat with in_fire in the flush cycle is consumed and discarded.
  - stall_cnt is unchanged.
  - Next cycle: out_valid=0, in_ready=1.
- Normal update (rst=1, flush=0), priority in this order:
  - Main empty and in_fire: the input loads into main.
  - Main full, out_fire, skid full: skid moves to main and skid empties. No in_fire is possible, because in_ready=0.
  - Main full, out_fire, skid empty, in_fire: the input loads into main (pass-through, 1-cycle latency).
  - Main full, out_fire, no in_fire: main empties.
  - Main full, no out_fire, in_fire: the input loads into skid, so in_ready drops next cycle.
  - Otherwise all entries hold.
- Latency and ordering:
  - Minimum latency is 1 cycle from in_fire to out_valid.
  - Ordering is strictly FIFO.
  - Throughput is 1 beat/cycle when out_ready=1 and stall=0.
- in_ready is a flop output (NOT skid_valid). It never depends combinationally on out_ready or stall.
- Stall behaviour:
  - stall=1 behaves as out_ready=0 for consumption.
  - Inputs are still accepted into any free entry, up to 2 beats.
- occupancy = main_valid + skid_valid. It is registered and updates with the entries.
- stall_cnt:
  - Increments when out_valid=1 and out_fire=0.
  - Saturates at 2^CNT_W−1 with no wrap.
  - Cleared only by reset.
- Fields are stored without any width conversion or arithmetic.

Test Plan:
- **Reset:** drive rst=0 for 2 cycles with in_valid=1 and in_ctrl=4'hF → out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0, stall_cnt=0.
- **Streaming:** out_ready=1, stall=0; send data 0x11, 0x22, 0x33 on consecutive cycles → each appears on out_data exactly 1 cycle later; in_ready stays 1; occupancy stays ≤1.
- **Backpressure/skid:** out_ready=0; send data A=0xAAAA0000 then B=0xBBBB0000 → after 2 cycles occupancy=2 and in_ready=0; C held on the input is not taken. Then raise out_ready → outputs A, B, C in order, with no loss or duplication.
- **Stall:** hold stall=1 for 5 cycles with out_valid=1 and out_ready=1 → out_data constant and stall_cnt advances by 5. Release stall → the beat is consumed.
- **Flush:** with occupancy=2, assert flush for 1 cycle together with in_valid=1 and in_rd=5'd7 → next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; the rd=7 beat never appears on the output.
- **Saturation:** CNT_W=3; hold out_ready=0 with out_valid=1 for 10 cycles → stall_cnt=7 and remains 7.
